dds_io_update_gen: RTL

Multi-channel IO_UPDATE generator for the DDS chips, between the PS register interface and the DDS IO_UPDATE pins. Each channel resynchronises an asynchronous PS request into `clk` and drives its pin in one of three modes: synchronised level passthrough, fixed-width pulse on a request rising edge, or periodic pulses from a shared interval counter. In periodic mode every channel updates on the same cycle. Requests that arrive while a channel's pulse is still in progress are flagged per channel.

---
 rtl/dds_io_update_gen.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/dds_io_update_gen.sv
// IO_UPDATE generator for the DDS chips: per-channel request synchroniser feeding
// passthrough, edge-triggered fixed-width pulses, or shared-interval periodic pulses.
module dds_io_update_gen #(
  parameter int NCH         = 2,
  parameter int SYNC_STAGES = 2,
  parameter int WIDTH_W     = 8,
  parameter int PERIOD_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NCH-1:0]      ps_dds_update,
  input  logic [1:0]          mode,
  input  logic [WIDTH_W-1:0]  pulse_len,
  input  logic [PERIOD_W-1:0] period,
  input  logic                clr_overrun,
  output logic [NCH-1:0]      o_dds_update,
  output logic [NCH-1:0]      busy,
  output logic [NCH-1:0]      overrun
);

  localparam logic [1:0] MODE_PASS     = 2'd0;
  localparam logic [1:0] MODE_EDGE     = 2'd1;
  localparam logic [1:0] MODE_PERIODIC = 2'd2;
  localparam logic [1:0] MODE_OFF      = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  logic [1:0]          mode_q;
  logic [1:0]          mode_prev_q;
  logic                mode_chg;
  logic [PERIOD_W-1:0] cnt_q;
  logic [PERIOD_W-1:0] cnt_d;
  logic                tick;
  logic [WIDTH_W-1:0]  len_eff;

  assign mode_chg = (mode_q != mode_prev_q);
  assign len_eff  = (pulse_len == '0) ? WIDTH_W'(1) : pulse_len;

  // >= rather than == so shrinking the period below the running count ticks at once
  assign tick = (mode_q == MODE_PERIODIC) && !mode_chg && (period != '0) &&
                (cnt_q >= (period - PERIOD_W'(1)));

  always_comb begin
    cnt_d = cnt_q + PERIOD_W'(1);
    if ((mode_q != MODE_PERIODIC) || mode_chg || (period == '0) || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q      <= MODE_PASS;
      mode_prev_q <= MODE_PASS;
      cnt_q       <= '0;
    end else begin
      mode_q      <= mode;
      mode_prev_q <= mode_q;
      cnt_q       <= cnt_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   prev_q;
      logic                   pass_q;
      logic                   out_q;
      logic                   out_d;
      logic                   busy_q;
      logic                   busy_d;
      logic                   ovr_q;
      logic                   ovr_d;
      logic                   ovr_set;
      logic                   sync_w;
      logic                   rise;
      logic                   trig;
      logic                   fsm_run;
      state_t                 state_q;
      state_t                 state_d;
      logic [WIDTH_W-1:0]     len_q;
      logic [WIDTH_W-1:0]     len_d;

      assign sync_w  = sync_q[SYNC_STAGES-1];
      assign rise    = sync_w & ~prev_q;
      assign fsm_run = (mode_q == MODE_EDGE) || (mode_q == MODE_PERIODIC);
      assign trig    = !mode_chg &&
                       (((mode_q == MODE_EDGE) && rise) ||
                        ((mode_q == MODE_PERIODIC) && tick));

      always_comb begin
        state_d = state_q;
        len_d   = len_q;
        ovr_set = 1'b0;
        if (mode_chg || !fsm_run) begin
          state_d = ST_IDLE;
          len_d   = '0;
        end else begin
          case (state_q)
            ST_IDLE: begin
              if (trig) begin
                state_d = ST_PULSE;
                len_d   = len_eff;
              end
            end
            ST_PULSE: begin
              ovr_set = trig;
              if (len_q <= WIDTH_W'(1)) begin
                state_d = ST_HOLD;
                len_d   = '0;
              end else begin
                len_d = len_q - WIDTH_W'(1);
              end
            end
            ST_HOLD: begin
              ovr_set = trig;
              state_d = ST_IDLE;
            end
            default: begin
              state_d = ST_IDLE;
              len_d   = '0;
            end
          endcase
        end
      end

      // Passthrough goes through pass_q so both modes share one extra register stage
      always_comb begin
        out_d  = 1'b0;
        busy_d = 1'b0;
        if (!mode_chg) begin
          case (mode_q)
            MODE_PASS: out_d = pass_q;
            MODE_EDGE, MODE_PERIODIC: begin
              out_d  = (state_q == ST_PULSE);
              busy_d = (state_q != ST_IDLE);
            end
            MODE_OFF: out_d = 1'b0;
            default:  out_d = 1'b0;
          endcase
        end
      end

      always_comb begin
        ovr_d = ovr_q;
        if (ovr_set) begin
          ovr_d = 1'b1;
        end else if (clr_overrun) begin
          ovr_d = 1'b0;
        end
      end

      if (SYNC_STAGES > 1) begin : g_sync
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            sync_q <= '0;
          end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ps_dds_update[gi]};
          end
        end
      end else begin : g_sync1
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            sync_q <= '0;
          end else begin
            sync_q <= ps_dds_update[gi];
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          prev_q  <= 1'b0;
          pass_q  <= 1'b0;
          out_q   <= 1'b0;
          busy_q  <= 1'b0;
          ovr_q   <= 1'b0;
          state_q <= ST_IDLE;
          len_q   <= '0;
        end else begin
          prev_q  <= sync_w;
          pass_q  <= sync_w;
          out_q   <= out_d;
          busy_q  <= busy_d;
          ovr_q   <= ovr_d;
          state_q <= state_d;
          len_q   <= len_d;
        end
      end

      assign o_dds_update[gi] = out_q;
      assign busy[gi]         = busy_q;
      assign overrun[gi]      = ovr_q;
    end
  endgenerate

endmodule
